// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: memory-side responder for the 16-bit single-cycle cpu.
//
// Holds two word stores:
// - an instruction store, written through a program-load port;
// - a data store, used by cpu loads and stores.
// Data accesses take WAIT_STATES stall cycles. When WAIT_STATES is 0 the
// data path is combinational and never stalls.
//
// Ports:
//   clk, reset              clock; synchronous active-low reset
//   pc                      instruction word address
//   instruction             imem word at pc (0 when out of range or in reset)
//   mem_read, mem_write     data request (both high = write)
//   alu_result              data word address
//   mem_write_data          store data
//   read_data               load result
//   stall                   cpu must hold pc/request while high
//   load_en/addr/data       instruction-store write port
//   addr_err                sticky out-of-range data address flag
//
// Optional build macro MEM_ACCESS_COUNT_EN adds read_count / write_count.
// These are saturating counts of completed in-range reads and writes.
//
// state | meaning
// IDLE  | no access in flight; a request latches and starts an access
// WAIT  | counting down remaining stall cycles
// DONE  | access completed; one cycle in which the held request is ignored

module cpu_mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          pc,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [15:0]          alu_result,
  input  logic [15:0]          mem_write_data,
  input  logic                 load_en,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [15:0]          load_data,
  output logic [15:0]          instruction,
  output logic [15:0]          read_data,
  output logic                 stall,
  output logic                 addr_err
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [15:0]          read_count,
  output logic [15:0]          write_count
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  logic [15:0] imem [DEPTH];
  logic [15:0] dmem [DEPTH];

  logic                 req;
  logic                 cpu_oor;
  logic                 pc_oor;
  logic [ADDR_BITS-1:0] cpu_addr;

  // Access performed at the coming clock edge.
  logic                 acc_do;
  logic                 acc_wr;
  logic                 acc_oor;
  logic [ADDR_BITS-1:0] acc_addr;
  logic [15:0]          acc_data;

  logic addr_err_q;

  assign req      = mem_read | mem_write;
  assign cpu_addr = alu_result[ADDR_BITS-1:0];
  assign cpu_oor  = (alu_result >> ADDR_BITS) != 16'd0;
  assign pc_oor   = (pc >> ADDR_BITS) != 16'd0;

  always_ff @(posedge clk) begin
    if (load_en) imem[load_addr] <= load_data;
  end

  assign instruction = (!reset || pc_oor) ? 16'h0000 : imem[pc[ADDR_BITS-1:0]];

  // Reset has priority, so an access in flight when reset asserts never commits.
  always_ff @(posedge clk) begin
    if (reset && acc_do && acc_wr && !acc_oor) dmem[acc_addr] <= acc_data;
  end

  always_ff @(posedge clk) begin
    if (!reset)                 addr_err_q <= 1'b0;
    else if (acc_do && acc_oor) addr_err_q <= 1'b1;
  end

  assign addr_err = addr_err_q;

  if (WAIT_STATES == 0) begin : g_zero_wait
    always_comb begin
      acc_do   = req;
      acc_wr   = mem_write;
      acc_oor  = cpu_oor;
      acc_addr = cpu_addr;
      acc_data = mem_write_data;
    end

    assign stall     = 1'b0;
    assign read_data = cpu_oor ? 16'h0000 : dmem[cpu_addr];
  end else begin : g_fsm
    // The IDLE cycle is the first stall cycle, so WAIT counts WAIT_STATES-2 down to 0.
    localparam int CNT_W = (WAIT_STATES > 2) ? $clog2(WAIT_STATES - 1) : 1;

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 lat_wr_q;
    logic                 lat_oor_q;
    logic [ADDR_BITS-1:0] lat_addr_q;
    logic [15:0]          lat_data_q;
    logic [15:0]          read_data_q;

    always_comb begin
      acc_do   = 1'b0;
      acc_wr   = lat_wr_q;
      acc_oor  = lat_oor_q;
      acc_addr = lat_addr_q;
      acc_data = lat_data_q;
      // Single-wait accesses complete at the IDLE edge straight from the cpu inputs.
      if (state_q == S_IDLE && req && WAIT_STATES == 1) begin
        acc_do   = 1'b1;
        acc_wr   = mem_write;
        acc_oor  = cpu_oor;
        acc_addr = cpu_addr;
        acc_data = mem_write_data;
      end else if (state_q == S_WAIT && cnt_q == '0) begin
        acc_do = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q     <= S_IDLE;
        cnt_q       <= '0;
        lat_wr_q    <= 1'b0;
        lat_oor_q   <= 1'b0;
        lat_addr_q  <= '0;
        lat_data_q  <= '0;
        read_data_q <= '0;
      end else begin
        if (acc_do && !acc_wr) read_data_q <= acc_oor ? 16'h0000 : dmem[acc_addr];
        case (state_q)
          S_IDLE: begin
            if (req) begin
              lat_wr_q   <= mem_write;
              lat_oor_q  <= cpu_oor;
              lat_addr_q <= cpu_addr;
              lat_data_q <= mem_write_data;
              if (WAIT_STATES >= 2) begin
                cnt_q   <= CNT_W'(WAIT_STATES - 2);
                state_q <= S_WAIT;
              end else begin
                state_q <= S_DONE;
              end
            end
          end
          S_WAIT: begin
            if (cnt_q == '0) state_q <= S_DONE;
            else             cnt_q   <= cnt_q - CNT_W'(1);
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end

    assign stall     = reset && ((state_q == S_IDLE && req) || state_q == S_WAIT);
    assign read_data = read_data_q;
  end

`ifdef MEM_ACCESS_COUNT_EN
  logic [15:0] read_count_q;
  logic [15:0] write_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      read_count_q  <= '0;
      write_count_q <= '0;
    end else if (acc_do && !acc_oor) begin
      if (acc_wr && write_count_q != 16'hFFFF) write_count_q <= write_count_q + 16'd1;
      if (!acc_wr && read_count_q != 16'hFFFF) read_count_q  <= read_count_q + 16'd1;
    end
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc;
  logic        load_en;
  logic [7:0]  load_addr;
  logic [15:0] load_data;

  logic        rd3, wr3, rd0, wr0, rd1, wr1;
  logic [15:0] a3, d3, a0, d0, a1, d1;
  logic [15:0] instr3, instr0, instr1;
  logic [15:0] rdata3, rdata0, rdata1;
  logic        stall3, stall0, stall1;
  logic        aerr3, aerr0, aerr1;
`ifdef MEM_ACCESS_COUNT_EN
  logic [15:0] rc3, wc3, rc0, wc0, rc1, wc1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .pc(pc), .mem_read(rd3), .mem_write(wr3),
    .alu_result(a3), .mem_write_data(d3), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .instruction(instr3), .read_data(rdata3), .stall(stall3),
    .addr_err(aerr3)
`ifdef MEM_ACCESS_COUNT_EN
    , .read_count(rc3), .write_count(wc3)
`endif
  );

  cpu_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .pc(pc), .mem_read(rd0), .mem_write(wr0),
    .alu_result(a0), .mem_write_data(d0), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .instruction(instr0), .read_data(rdata0), .stall(stall0),
    .addr_err(aerr0)
`ifdef MEM_ACCESS_COUNT_EN
    , .read_count(rc0), .write_count(wc0)
`endif
  );

  cpu_mem_responder #(.ADDR_BITS(8), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .pc(pc), .mem_read(rd1), .mem_write(wr1),
    .alu_result(a1), .mem_write_data(d1), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .instruction(instr1), .read_data(rdata1), .stall(stall1),
    .addr_err(aerr1)
`ifdef MEM_ACCESS_COUNT_EN
    , .read_count(rc1), .write_count(wc1)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int which, input logic w, input logic r,
                       input logic [15:0] a, input logic [15:0] d);
    case (which)
      3:       begin wr3 = w; rd3 = r; a3 = a; d3 = d; end
      0:       begin wr0 = w; rd0 = r; a0 = a; d0 = d; end
      default: begin wr1 = w; rd1 = r; a1 = a; d1 = d; end
    endcase
  endtask

  function automatic logic cur_stall(input int which);
    case (which)
      3:       return stall3;
      0:       return stall0;
      default: return stall1;
    endcase
  endfunction

  function automatic logic [15:0] cur_rd(input int which);
    case (which)
      3:       return rdata3;
      0:       return rdata0;
      default: return rdata1;
    endcase
  endfunction

  // Runs one access, counts stall cycles (bounded), samples read_data in the
  // first non-stall cycle, then drops the request for one cycle.
  task automatic access(input int which, input logic w, input logic r,
                        input logic [15:0] a, input logic [15:0] d,
                        output int n, output logic [15:0] rdq);
    drive(which, w, r, a, d);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (cur_stall(which)) begin
        n++;
        step();
      end else begin
        break;
      end
    end
    rdq = cur_rd(which);
    drive(which, 1'b0, 1'b0, a, d);
    step();
  endtask

  int          n;
  logic [15:0] rq;

  initial begin
    reset = 1'b0; pc = 16'h0000; load_en = 1'b0; load_addr = '0; load_data = '0;
    drive(3, 0, 0, 0, 0); drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    step(); step();
    #1;
    chk("rst_stall3", {15'd0, stall3}, 16'h0000);
    chk("rst_instr3", instr3, 16'h0000);
    chk("rst_rdata3", rdata3, 16'h0000);
    chk("rst_aerr3", {15'd0, aerr3}, 16'h0000);
    chk("rst_rdata1", rdata1, 16'h0000);
    reset = 1'b1;
    step();

    // program load and fetch sweep
    load_en = 1'b1; load_addr = 8'd0; load_data = 16'h1234; step();
    load_addr = 8'd1; load_data = 16'hABCD; step();
    load_addr = 8'd2; load_data = 16'h0F0F; step();
    load_en = 1'b0;
    pc = 16'h0000; #1 chk("instr_pc0", instr3, 16'h1234);
    pc = 16'h0001; #1 chk("instr_pc1", instr3, 16'hABCD);
    pc = 16'h0002; #1 chk("instr_pc2", instr3, 16'h0F0F);
    pc = 16'h0100; #1 chk("instr_pc_oor", instr3, 16'h0000);
    pc = 16'h0002; load_en = 1'b1; load_addr = 8'd2; load_data = 16'h5555;
    #1 chk("instr_before_load", instr1, 16'h0F0F);
    step();
    load_en = 1'b0;
    #1 chk("instr_after_load", instr1, 16'h5555);

    // three-wait-state instance
    access(3, 1, 0, 16'h0010, 16'hBEEF, n, rq);
    chk("ws3_wr_stalls", 16'(n), 16'd3);
    access(3, 0, 1, 16'h0010, 16'h0000, n, rq);
    chk("ws3_rd_stalls", 16'(n), 16'd3);
    chk("ws3_rd_data", rq, 16'hBEEF);
    access(3, 1, 1, 16'h0030, 16'h1111, n, rq);
    chk("ws3_both_stalls", 16'(n), 16'd3);
    chk("ws3_both_rd_hold", rq, 16'hBEEF);
    access(3, 0, 1, 16'h0030, 16'h0000, n, rq);
    chk("ws3_rd30", rq, 16'h1111);
    access(3, 1, 0, 16'h0000, 16'h2222, n, rq);
    chk("ws3_aerr_clean", {15'd0, aerr3}, 16'h0000);
    access(3, 1, 0, 16'h0200, 16'h9999, n, rq);
    chk("ws3_oor_wr_stalls", 16'(n), 16'd3);
    chk("ws3_oor_aerr", {15'd0, aerr3}, 16'h0001);
    access(3, 0, 1, 16'h0200, 16'h0000, n, rq);
    chk("ws3_oor_rd_zero", rq, 16'h0000);
    access(3, 0, 1, 16'h0000, 16'h0000, n, rq);
    chk("ws3_oor_mem_intact", rq, 16'h2222);
    chk("ws3_aerr_sticky", {15'd0, aerr3}, 16'h0001);
    access(3, 1, 0, 16'h0040, 16'h1357, n, rq);
`ifdef MEM_ACCESS_COUNT_EN
    chk("ws3_rd_count", rc3, 16'd3);
    chk("ws3_wr_count", wc3, 16'd4);
`endif

    // zero-wait instance
    drive(0, 1, 0, 16'h0020, 16'h5A5A);
    #1 chk("ws0_wr_stall", {15'd0, stall0}, 16'h0000);
    step();
    drive(0, 0, 1, 16'h0020, 16'h0000);
    #1 chk("ws0_rd_data", rdata0, 16'h5A5A);
    chk("ws0_rd_stall", {15'd0, stall0}, 16'h0000);
    step();
    drive(0, 0, 1, 16'h0300, 16'h0000);
    #1 chk("ws0_oor_rd", rdata0, 16'h0000);
    step();
    drive(0, 0, 0, 16'h0000, 16'h0000);
    #1 chk("ws0_oor_aerr", {15'd0, aerr0}, 16'h0001);

    // single-wait-state instance
    access(1, 1, 0, 16'h0005, 16'h00C3, n, rq);
    chk("ws1_wr_stalls", 16'(n), 16'd1);
    access(1, 0, 1, 16'h0005, 16'h0000, n, rq);
    chk("ws1_rd_stalls", 16'(n), 16'd1);
    chk("ws1_rd_data", rq, 16'h00C3);

    // reset during the second stall cycle of a write
    drive(3, 1, 0, 16'h0040, 16'hCAFE);
    #1 chk("rstmid_stall1", {15'd0, stall3}, 16'h0001);
    step();
    #1 chk("rstmid_stall2", {15'd0, stall3}, 16'h0001);
    reset = 1'b0;
    #1 chk("rstmid_stall_low", {15'd0, stall3}, 16'h0000);
    step(); step();
    drive(3, 0, 0, 16'h0000, 16'h0000);
    reset = 1'b1;
    #1 chk("rstmid_aerr_clr", {15'd0, aerr3}, 16'h0000);
    chk("rstmid_rdata_clr", rdata3, 16'h0000);
`ifdef MEM_ACCESS_COUNT_EN
    chk("rstmid_rd_count", rc3, 16'd0);
    chk("rstmid_wr_count", wc3, 16'd0);
`endif
    step();
    access(3, 0, 1, 16'h0040, 16'h0000, n, rq);
    chk("rstmid_rd_stalls", 16'(n), 16'd3);
    chk("rstmid_no_commit", rq, 16'h1357);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the 16-bit single-cycle cpu. Serves instruction fetch from pc and data loads/stores from the cpu's memWrite/aluResult/memWriteData outputs.
- Returns instruction and readData to the cpu.
- Inserts a parameterised number of wait states on data accesses using a stall handshake.
- Holds a separate instruction store, filled through a load port; a data store for cpu accesses.

Parameters:
ADDR_BITS, 8, word-address bits per memory; each store holds 2**ADDR_BITS 16-bit words
WAIT_STATES, 1, stall cycles per data access; 0 = zero-wait (legal)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
pc  input  16  instruction word address from cpu
mem_read  input  1  cpu data load request
mem_write  input  1  cpu data store request
alu_result  input  16  data word address
mem_write_data  input  16  store data
load_en  input  1  instruction-store write enable (program loader)
load_addr  input  ADDR_BITS  instruction-store write address
load_data  input  16  instruction-store write data
instruction  output  16  instruction word at pc
read_data  output  16  load result
stall  output  1  cpu must hold pc and request while high
addr_err  output  1  sticky out-of-range data address flag

Behaviour:
- Reset (reset==0 at posedge): state IDLE, wait counter 0, read_data 0, addr_err 0, any pending access discarded. stall=0 and instruction=16'h0000 combinationally while reset low. Memory arrays are not cleared.
- Instruction path:
  - instruction = imem[pc[ADDR_BITS-1:0]], combinational.
  - pc upper bits nonzero -> 16'h0000.
  - load_en writes imem at posedge, independent of the data FSM.
  - A load to the address being fetched shows new data the cycle after.
- Request: req = mem_read | mem_write. When both are high it is a write; read_data is unchanged.
- FSM states IDLE, WAIT, DONE:
  - IDLE & req:
    - Latch address, data and type.
    - WAIT_STATES>=2: cnt <= WAIT_STATES-2, go to WAIT.
    - WAIT_STATES==1: perform access at this edge, go to DONE.
  - WAIT: cnt==0 -> perform access, go to DONE; else cnt--.
  - DONE: go to IDLE unconditionally; the held request is not re-latched.
- stall = (state==IDLE & req) | state==WAIT, so there are exactly WAIT_STATES stall cycles per access.
- Changes to cpu inputs during WAIT are ignored; the latched copy is used.
- Perform access:
  - Write: dmem[addr] <= data.
  - Read: read_data <= dmem[addr]; it holds until the next completed read or reset.
- Zero-wait mode (WAIT_STATES==0):
  - FSM bypassed; stall is always 0.
  - read_data = dmem[alu_result] combinational.
  - Write commits at the posedge where mem_write is high.
- Out of range (alu_result[15:ADDR_BITS]!=0):
  - Write dropped; read returns 16'h0000.
  - addr_err set at completion; cleared only by reset.
- Reset mid-access: an in-flight write is not committed; the FSM returns to IDLE.
- Back-to-back accesses: the minimum gap is the single DONE cycle. A new request in the cycle after DONE starts a fresh access.

Optional Feature:
- Macro MEM_ACCESS_COUNT_EN.
- Defined: adds outputs read_count[15:0] and write_count[15:0].
  - Incremented on each completed in-range read/write.
  - Saturate at 16'hFFFF; reset to 0.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset, then load imem[0..2] = 16'h1234, 16'hABCD, 16'h0F0F via load port; sweep pc 0,1,2,3 -> instruction 1234, ABCD, 0F0F, then the unloaded value; pc=16'h0100 with ADDR_BITS=8 -> 0000.
- WAIT_STATES=3: mem_write=1, alu_result=16'h0010, data=16'hBEEF -> stall high exactly 3 cycles; then mem_read at 0x0010 -> stall 3 cycles, read_data=BEEF in DONE cycle.
- WAIT_STATES=0: store 16'h5A5A to 0x0020, next cycle mem_read 0x0020 -> read_data=5A5A same cycle, stall never high.
- mem_read and mem_write both high to 0x0030 with data 16'h1111 after read_data=BEEF -> dmem[0x30]=1111, read_data stays BEEF.
- Write to 16'h0200 (out of range) -> stall behaves normally, memory unchanged, addr_err=1 and stays 1 across later valid accesses until reset.
- reset low during 2nd stall cycle of a write of 16'hCAFE to 0x0040 -> stall 0, dmem[0x40] unchanged, next read from 0x0040 returns prior value; with MEM_ACCESS_COUNT_EN, counters read 0 after reset.
